pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction field width.
REQ-002 SHALL have parameter PAYLOAD_W, default 32, side payload width (e.g. PC+4).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, bubble instruction value (INSTR_W bits).
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  in  1  hold all state; no accept, no send.
REQ-007 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-008 SHALL have port in_valid  in  1  upstream entry present.
REQ-009 SHALL have port in_ready  out  1  block can accept this cycle.
REQ-010 SHALL have port in_instr  in  INSTR_W  upstream instruction.
REQ-011 SHALL have port in_payload  in  PAYLOAD_W  upstream payload.
REQ-012 SHALL have port out_valid  out  1  downstream entry present.
REQ-013 SHALL have port out_ready  in  1  downstream can take entry.
REQ-014 SHALL have port out_instr  out  INSTR_W  head instruction.
REQ-015 SHALL have port out_payload  out  PAYLOAD_W  head payload.
REQ-016 SHALL have port occupancy  out  2  entries held (0..2).
REQ-017 SHALL have port stall_cycles  out  32  perf counter (see Configuration).
REQ-018 SHALL have port flush_count  out  32  perf counter (see Configuration).

Function
REQ-019 SHALL implement a 2-entry in-order skid buffer, states EMPTY/ONE/TWO, occupancy = 0/1/2.
REQ-020 SHALL drive in_ready = !stall && !flush && state!=TWO.
REQ-021 SHALL define accept = in_valid && in_ready, send = out_valid && out_ready && !stall && !flush.
REQ-022 SHALL drive out_valid = (state!=EMPTY), a function of registered state only.
REQ-023 SHALL transition EMPTY->ONE on accept; otherwise stay EMPTY.
REQ-024 SHALL, in ONE: accept&!send -> TWO; send&!accept -> EMPTY; accept&send -> ONE with new entry at head; neither -> ONE.
REQ-025 SHALL, in TWO: send -> ONE with skid entry promoted to head; otherwise stay TWO.
REQ-026 SHALL preserve entry order; no entry duplicated or dropped except by flush/rst.
REQ-027 SHALL present an accepted entry at out_* one cycle after the accepting edge when EMPTY beforehand.
REQ-028 SHALL drive out_instr = NOP_INSTR and out_payload = 0 whenever out_valid = 0.
REQ-029 SHALL, while stall=1 and flush=0, keep state, occupancy and all out_* unchanged.
REQ-030 SHALL, on an edge with flush=1, go to EMPTY and discard held and same-cycle input; flush overrides stall, accept and send.
REQ-031 SHALL sustain one transfer per cycle when in_valid=out_ready=1 and stall=flush=0.

Reset
REQ-032 SHALL, while rst=1, asynchronously force state EMPTY, occupancy 0, out_valid 0, out_instr NOP_INSTR, out_payload 0, counters 0.
REQ-033 SHALL discard any held entries on reset asserted mid-operation; in_ready = !stall && !flush while and after rst.

Configuration
REQ-034 SHALL compile perf counters in only when macro PIPE_STAGE_REG_PERF_EN is defined.
REQ-035 SHALL, with PIPE_STAGE_REG_PERF_EN: stall_cycles +1 per edge with stall=1 and out_valid=1; flush_count +1 per edge with flush=1 and occupancy>0; both saturate at 32'hFFFFFFFF.
REQ-036 SHALL, without PIPE_STAGE_REG_PERF_EN, keep both ports and tie them to 0.

Verification
REQ-037 SHALL cover streaming: in_valid=1, out_ready=1, instr 0x100..0x104 on consecutive cycles -> same sequence out one cycle later, occupancy 1 steady.
REQ-038 SHALL cover backpressure: out_ready=0, push A, B -> occupancy 2, in_ready=0; out_ready=1 -> A then B, no loss.
REQ-039 SHALL cover stall: occupancy 1, head 0xABC, stall=1 for 3 cycles -> out_* frozen at 0xABC, in_ready=0, stall_cycles=3 (perf build).
REQ-040 SHALL cover flush with stall and in_valid: occupancy 2, stall=1, flush=1 -> next cycle occupancy 0, out_instr 0x00000013, out_payload 0, flush_count=1.
REQ-041 SHALL cover async reset: occupancy 2, rst pulse between edges -> out_valid 0 and out_instr 0x00000013 immediately, counters 0.
REQ-042 SHALL cover saturation: preload/force stall_cycles 32'hFFFFFFFE, 3 stalled cycles -> 32'hFFFFFFFF held.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry in-order skid buffer between pipeline stages with
//               stall/flush control. Perf counters compiled in only when
//               PIPE_STAGE_REG_PERF_EN is defined; otherwise tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PAYLOAD_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   head_instr_q, head_instr_d;
    logic [PAYLOAD_W-1:0] head_payload_q, head_payload_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;

    logic w_accept;
    logic w_send;

    assign out_valid   = (state_q != ST_EMPTY);
    assign in_ready    = !stall && !flush && (state_q != ST_TWO);
    assign w_accept    = in_valid && in_ready;
    assign w_send      = out_valid && out_ready && !stall && !flush;
    assign occupancy   = state_q;
    assign out_instr   = out_valid ? head_instr_q : NOP_INSTR;
    assign out_payload = out_valid ? head_payload_q : '0;

    always_comb begin
        state_d        = state_q;
        head_instr_d   = head_instr_q;
        head_payload_d = head_payload_q;
        skid_instr_d   = skid_instr_q;
        skid_payload_d = skid_payload_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d        = ST_ONE;
                        head_instr_d   = in_instr;
                        head_payload_d = in_payload;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_send) begin
                        state_d        = ST_TWO;
                        skid_instr_d   = in_instr;
                        skid_payload_d = in_payload;
                    end else if (!w_accept && w_send) begin
                        state_d = ST_EMPTY;
                    end else if (w_accept && w_send) begin
                        head_instr_d   = in_instr;
                        head_payload_d = in_payload;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a send can happen.
                    if (w_send) begin
                        state_d        = ST_ONE;
                        head_instr_d   = skid_instr_q;
                        head_payload_d = skid_payload_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            head_instr_q   <= NOP_INSTR;
            head_payload_q <= '0;
            skid_instr_q   <= NOP_INSTR;
            skid_payload_q <= '0;
        end else begin
            state_q        <= state_d;
            head_instr_q   <= head_instr_d;
            head_payload_q <= head_payload_d;
            skid_instr_q   <= skid_instr_d;
            skid_payload_q <= skid_payload_d;
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && out_valid && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (state_q != ST_EMPTY) && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg: directed vector table,
//               async reset / saturation sequences, randomized queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [31:0] c_nop = 32'h00000013;
`ifdef PIPE_STAGE_REG_PERF_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_payload;
    logic [1:0]  occupancy;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_payload (out_payload),
        .occupancy   (occupancy),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          flush;
        bit          iv;
        logic [31:0] instr;
        logic [31:0] pay;
        bit          ordy;
        bit          exp_inrdy;
        logic [1:0]  exp_occ;
        logic [31:0] exp_instr;
        logic [31:0] exp_pay;
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pay;
    } entry_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit f, input bit iv, input logic [31:0] ins,
                         input logic [31:0] pay, input bit ordy);
        stall      = s;
        flush      = f;
        in_valid   = iv;
        in_instr   = ins;
        in_payload = pay;
        out_ready  = ordy;
    endtask

    function automatic vec_t mk(bit s, bit f, bit iv, logic [31:0] ins, logic [31:0] pay, bit ordy,
                                bit ir, logic [1:0] occ, logic [31:0] ei, logic [31:0] ep,
                                logic [31:0] sc, logic [31:0] fc);
        vec_t v;
        v.stall = s; v.flush = f; v.iv = iv; v.instr = ins; v.pay = pay; v.ordy = ordy;
        v.exp_inrdy = ir; v.exp_occ = occ; v.exp_instr = ei; v.exp_pay = ep;
        v.exp_sc = sc; v.exp_fc = fc;
        return v;
    endfunction

    task automatic check_outs(input string tag, input logic [1:0] occ, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, ".occ"},   occupancy,    occ);
        chk({tag, ".valid"}, out_valid,    (occ != 2'd0));
        chk({tag, ".instr"}, out_instr,    ei);
        chk({tag, ".pay"},   out_payload,  ep);
        chk({tag, ".sc"},    stall_cycles, c_perf ? sc : 32'd0);
        chk({tag, ".fc"},    flush_count,  c_perf ? fc : 32'd0);
    endtask

    vec_t   vt[21];
    entry_t q[$];
    logic [63:0] m_sc;
    logic [63:0] m_fc;

    initial begin
        // Streaming, backpressure, stall, and flush-with-stall scenarios.
        vt[0]  = mk(0,0,1,32'h100,32'h1100,1, 1,1,32'h100,32'h1100, 0,0);
        vt[1]  = mk(0,0,1,32'h101,32'h1101,1, 1,1,32'h101,32'h1101, 0,0);
        vt[2]  = mk(0,0,1,32'h102,32'h1102,1, 1,1,32'h102,32'h1102, 0,0);
        vt[3]  = mk(0,0,1,32'h103,32'h1103,1, 1,1,32'h103,32'h1103, 0,0);
        vt[4]  = mk(0,0,1,32'h104,32'h1104,1, 1,1,32'h104,32'h1104, 0,0);
        vt[5]  = mk(0,0,0,32'h0,  32'h0,   1, 1,0,c_nop,  32'h0,    0,0);
        vt[6]  = mk(0,0,1,32'hA,  32'hAA,  0, 1,1,32'hA,  32'hAA,   0,0);
        vt[7]  = mk(0,0,1,32'hB,  32'hBB,  0, 1,2,32'hA,  32'hAA,   0,0);
        vt[8]  = mk(0,0,1,32'hC,  32'hCC,  0, 0,2,32'hA,  32'hAA,   0,0);
        vt[9]  = mk(0,0,0,32'h0,  32'h0,   1, 0,1,32'hB,  32'hBB,   0,0);
        vt[10] = mk(0,0,0,32'h0,  32'h0,   1, 1,0,c_nop,  32'h0,    0,0);
        vt[11] = mk(0,0,1,32'hABC,32'h5,   0, 1,1,32'hABC,32'h5,    0,0);
        vt[12] = mk(1,0,1,32'hDEF,32'h6,   1, 0,1,32'hABC,32'h5,    1,0);
        vt[13] = mk(1,0,1,32'hDEF,32'h6,   1, 0,1,32'hABC,32'h5,    2,0);
        vt[14] = mk(1,0,1,32'hDEF,32'h6,   1, 0,1,32'hABC,32'h5,    3,0);
        vt[15] = mk(0,0,0,32'h0,  32'h0,   1, 1,0,c_nop,  32'h0,    3,0);
        vt[16] = mk(0,0,1,32'h1,  32'h11,  0, 1,1,32'h1,  32'h11,   3,0);
        vt[17] = mk(0,0,1,32'h2,  32'h22,  0, 1,2,32'h1,  32'h11,   3,0);
        vt[18] = mk(1,1,1,32'h3,  32'h33,  1, 0,0,c_nop,  32'h0,    4,1);
        vt[19] = mk(0,1,1,32'h4,  32'h44,  1, 0,0,c_nop,  32'h0,    4,1);
        vt[20] = mk(0,0,1,32'h7,  32'h77,  1, 1,1,32'h7,  32'h77,   4,1);

        rst = 1'b1;
        drive(0,0,0,32'h0,32'h0,0);
        #1;
        check_outs("reset", 2'd0, c_nop, 32'h0, 0, 0);
        chk("reset.in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vt[i].stall, vt[i].flush, vt[i].iv, vt[i].instr, vt[i].pay, vt[i].ordy);
            #1;
            chk($sformatf("vec%0d.in_ready", i), in_ready, vt[i].exp_inrdy);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].exp_occ, vt[i].exp_instr, vt[i].exp_pay,
                       vt[i].exp_sc, vt[i].exp_fc);
        end

        // Async reset between edges with two entries held.
        @(negedge clk);
        drive(0,0,1,32'h8,32'h88,0);
        @(posedge clk);
        #1;
        chk("pre_rst.occ", occupancy, 2'd2);
        drive(0,0,0,32'h0,32'h0,0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 2'd0, c_nop, 32'h0, 0, 0);
        chk("async_rst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst", 2'd0, c_nop, 32'h0, 0, 0);

`ifdef PIPE_STAGE_REG_PERF_EN
        // Counter saturation from a preloaded near-max value.
        @(negedge clk);
        drive(0,0,1,32'h9,32'h99,0);
        @(posedge clk);
        @(negedge clk);
        drive(0,0,0,32'h0,32'h0,0);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1,0,0,32'h0,32'h0,1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d", i), stall_cycles, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        drive(0,0,0,32'h0,32'h0,0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
`endif

        // Randomized traffic against a queue-based reference model.
        q.delete();
        m_sc = 0;
        m_fc = 0;
        for (int i = 0; i < 2000; i++) begin
            bit s, f, iv, ordy, exp_rdy, acc, snd;
            logic [31:0] ins, pay;
            entry_t e;
            s    = ($urandom_range(0, 99) < 20);
            f    = ($urandom_range(0, 99) < 5);
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 60);
            ins  = $urandom;
            pay  = $urandom;
            @(negedge clk);
            drive(s, f, iv, ins, pay, ordy);
            exp_rdy = !s && !f && (q.size() < 2);
            acc = iv && exp_rdy;
            snd = (q.size() > 0) && ordy && !s && !f;
            if (s && q.size() > 0 && m_sc != 64'hFFFF_FFFF) m_sc++;
            if (f && q.size() > 0 && m_fc != 64'hFFFF_FFFF) m_fc++;
            if (f) begin
                q.delete();
            end else begin
                if (snd) void'(q.pop_front());
                if (acc) begin
                    e.instr = ins;
                    e.pay   = pay;
                    q.push_back(e);
                end
            end
            #1;
            chk($sformatf("rnd%0d.in_ready", i), in_ready, exp_rdy);
            @(posedge clk);
            #1;
            if (q.size() > 0)
                check_outs($sformatf("rnd%0d", i), 2'(q.size()), q[0].instr, q[0].pay,
                           m_sc[31:0], m_fc[31:0]);
            else
                check_outs($sformatf("rnd%0d", i), 2'd0, c_nop, 32'h0, m_sc[31:0], m_fc[31:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
